playfield_arbiter: RTL
======================

// Module: playfield_arbiter
// PURPOSE
//  Responder end of the falling-piece movement handshake. It samples the four candidate block coordinates
//  of a movement request and checks them against field bounds and a stored colour playfield. It answers with
//  commit, decline (player move) or steal (natural drop blocked: lock piece, clear full rows, respawn).
//  Also serves a registered colour read port to the renderer.
// PARAMETERS
//  FIELD_H  20  rows along the falling (h) axis, h=0 is top
//  FIELD_W  10  columns along the lateral (v) axis
// PORTS
//  clk                input   1  clock
//  reset              input   1  synchronous, active-low
//  movement_request   input   1  level; candidate position valid while high
//  movement_intent    input   1  0 = natural drop (h+1), 1 = player move/rotate
//  P1..P4blk_h        input   5  candidate row of each block (8 ports total with _v)
//  P1..P4blk_v        input   5  candidate column of each block
//  volatile_blk_color input   3  colour of falling piece, nonzero
//  movement_commit    output  1  one-cycle pulse: candidate accepted
//  movement_declined  output  1  level: player move refused
//  movement_steal     output  1  level: piece locked, initiator must respawn
//  rd_h               input   5  renderer read row
//  rd_v               input   5  renderer read column
//  rd_color           output  3  colour at (rd_h,rd_v) one cycle later; 0 = empty/out of range
//  lines_cleared      output  8  count of cleared rows, saturates at 255
//  game_over          output  1  sticky: a lock wrote a cell in row 0
// BEHAVIOUR
//  Reset (reset==0 at posedge): every field cell 0, FSM IDLE, all outputs 0, counter 0.
//   Reset mid-operation aborts immediately; no partial lock survives.
//  FSM IDLE->CHECK->{COMMIT|DECLINE|LOCK}; LOCK->SCAN<->SHIFT->STEAL; COMMIT/DECLINE/STEAL->WAIT_LOW->IDLE.
//  IDLE: request sampled 1 -> latch P1..P4 h/v, intent, colour; collide flag=0; go CHECK.
//  CHECK: 4 cycles, block k=0..3, one per cycle, always all 4, no early exit.
//   Block collides if h>=FIELD_H, or v>=FIELD_W, or cell(h,v)!=0. Lateral underflow wraps to 31, so it collides.
//  After CHECK, no collision -> COMMIT: commit=1 for exactly one cycle.
//   Latency: commit high 5 cycles after the IDLE sampling edge.
//  Collision, intent=1 -> DECLINE: declined=1.
//   Held until request is sampled 0, then declined=0 next cycle, go IDLE.
//  Collision, intent=0 -> LOCK: 4 cycles.
//   Write colour to cell(h-1,v) for block k. Latched h is >=1 for natural moves.
//   Row h-1==0 written -> game_over=1.
//  SCAN: row pointer r starts at FIELD_H-1.
//   Row r fully nonzero -> SHIFT.
//   Otherwise r-1; after r==0 is processed -> STEAL.
//  SHIFT: one row per cycle, k=r down to 1, row k <= row k-1; then row 0 <= 0.
//   Then lines_cleared+1 (saturating); back to SCAN at the same r, to handle stacked full rows.
//  STEAL: steal=1 held until request is sampled 0, then steal=0, go IDLE.
//  WAIT_LOW: after commit, wait for request sampled 0 before IDLE.
//   Prevents double-accepting one request; a new request may rise the following cycle.
//  Request dropping during CHECK/LOCK/SCAN/SHIFT: ignored; the sequence completes on the latched data.
//  commit/declined/steal are mutually exclusive; at most one is high in any cycle.
//  rd port: registered; out-of-range rd_h/rd_v gives 0.
//   During SHIFT the read returns the pre-edge array content.
//  game_over does not stall the handshake; it only flags.
// TESTING
//  Empty field, intent=0, blocks (1,4)(1,5)(2,5)(2,6) -> commit pulse at +5, no field change, then WAIT_LOW.
//  Intent=1, one block v=31 (wrapped) -> declined held until request=0, then 0; field unchanged.
//  Intent=0, a block at h=FIELD_H -> LOCK writes rows h-1 with colour 3; steal held until request=0;
//   rd_color=3 at written cells.
//  Preload row 19 with 9 cells (col 4 empty), drop an I piece filling (19,4) -> row shift,
//   lines_cleared=1, row 19 = old row 18, row 0 = 0.
//  Two stacked full rows cleared by one lock -> lines_cleared+=2; lock into row 0 -> game_over=1 stays;
//   reset=0 mid-SHIFT -> all cells 0, outputs 0.

Source files
------------

// File: rtl/playfield_arbiter.sv
// playfield_arbiter: responder side of the falling-piece movement handshake.
// Checks four candidate blocks against bounds and the colour playfield, then
// commits, declines, or locks the piece, clears full rows and signals steal.
module playfield_arbiter #(
  parameter int unsigned FIELD_H = 20,
  parameter int unsigned FIELD_W = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       movement_request,
  input  logic       movement_intent,
  input  logic [4:0] P1blk_h,
  input  logic [4:0] P1blk_v,
  input  logic [4:0] P2blk_h,
  input  logic [4:0] P2blk_v,
  input  logic [4:0] P3blk_h,
  input  logic [4:0] P3blk_v,
  input  logic [4:0] P4blk_h,
  input  logic [4:0] P4blk_v,
  input  logic [2:0] volatile_blk_color,
  output logic       movement_commit,
  output logic       movement_declined,
  output logic       movement_steal,
  input  logic [4:0] rd_h,
  input  logic [4:0] rd_v,
  output logic [2:0] rd_color,
  output logic [7:0] lines_cleared,
  output logic       game_over
);

  localparam int unsigned COORD_W = 5;
  localparam int unsigned COLOR_W = 3;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned NBLK    = 4;
  localparam int unsigned ROW_W   = $clog2(FIELD_H);
  localparam int unsigned COL_W   = $clog2(FIELD_W);
  localparam logic [COORD_W-1:0] H_LIM = COORD_W'(FIELD_H);
  localparam logic [COORD_W-1:0] W_LIM = COORD_W'(FIELD_W);

  typedef enum logic [3:0] {
    S_IDLE, S_CHECK, S_COMMIT, S_DECLINE, S_LOCK,
    S_SCAN, S_SHIFT, S_STEAL, S_WAIT_LOW
  } state_t;

  state_t             state, state_next;
  logic [1:0]         blk, blk_next;
  logic [ROW_W-1:0]   row_ptr, row_next;
  logic [ROW_W-1:0]   shift_k, shift_next;
  logic               collide, collide_next;
  logic               commit_next, declined_next, steal_next;
  logic               latch_en, wr_en, shift_en, clr_row0, lc_inc, go_set;

  logic [COORD_W-1:0] lat_h [NBLK];
  logic [COORD_W-1:0] lat_v [NBLK];
  logic               lat_intent;
  logic [COLOR_W-1:0] lat_color;

  logic [FIELD_W-1:0][COLOR_W-1:0] field [FIELD_H];

  logic [COORD_W-1:0] cur_h, cur_v, lock_h;
  logic [COLOR_W-1:0] cur_cell;
  logic               cur_in, cur_hit, lock_ok, row_full;

  // Per-block collision / lock-target evaluation and full-row detect at row_ptr
  always_comb begin
    cur_h    = lat_h[blk];
    cur_v    = lat_v[blk];
    cur_in   = (cur_h < H_LIM) && (cur_v < W_LIM);
    cur_cell = '0;
    if (cur_in) cur_cell = field[ROW_W'(cur_h)][COL_W'(cur_v)];
    cur_hit  = !cur_in || (cur_cell != '0);
    lock_h   = cur_h - COORD_W'(1);
    lock_ok  = (lock_h < H_LIM) && (cur_v < W_LIM);
    row_full = 1'b1;
    for (int unsigned c = 0; c < FIELD_W; c++) begin
      if (field[row_ptr][COL_W'(c)] == '0) row_full = 1'b0;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_next    = state;
    blk_next      = blk;
    row_next      = row_ptr;
    shift_next    = shift_k;
    collide_next  = collide;
    commit_next   = 1'b0;
    declined_next = movement_declined;
    steal_next    = movement_steal;
    latch_en      = 1'b0;
    wr_en         = 1'b0;
    shift_en      = 1'b0;
    clr_row0      = 1'b0;
    lc_inc        = 1'b0;
    go_set        = 1'b0;
    case (state)
      S_IDLE: begin
        if (movement_request) begin
          latch_en     = 1'b1;
          blk_next     = '0;
          collide_next = 1'b0;
          state_next   = S_CHECK;
        end
      end
      S_CHECK: begin
        collide_next = collide | cur_hit;
        blk_next     = blk + 2'd1;
        if (blk == 2'd3) begin
          if (collide | cur_hit) state_next = lat_intent ? S_DECLINE : S_LOCK;
          else                   state_next = S_COMMIT;
        end
      end
      S_COMMIT: begin
        commit_next = 1'b1;
        state_next  = S_WAIT_LOW;
      end
      S_DECLINE: begin
        declined_next = 1'b1;
        state_next    = S_WAIT_LOW;
      end
      S_LOCK: begin
        wr_en    = lock_ok;
        go_set   = lock_ok && (lock_h == '0);
        blk_next = blk + 2'd1;
        if (blk == 2'd3) begin
          row_next   = ROW_W'(FIELD_H - 1);
          state_next = S_SCAN;
        end
      end
      S_SCAN: begin
        if (row_full) begin
          shift_next = row_ptr;
          state_next = S_SHIFT;
        end else if (row_ptr == '0) begin
          state_next = S_STEAL;
        end else begin
          row_next = row_ptr - ROW_W'(1);
        end
      end
      S_SHIFT: begin
        if (shift_k != '0) begin
          shift_en   = 1'b1;
          shift_next = shift_k - ROW_W'(1);
        end else begin
          clr_row0   = 1'b1;
          lc_inc     = 1'b1;
          state_next = S_SCAN;
        end
      end
      S_STEAL: begin
        steal_next = 1'b1;
        state_next = S_WAIT_LOW;
      end
      S_WAIT_LOW: begin
        if (!movement_request) begin
          declined_next = 1'b0;
          steal_next    = 1'b0;
          state_next    = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // State, handshake outputs and status counters
  always_ff @(posedge clk) begin
    if (!reset) begin
      state             <= S_IDLE;
      blk               <= '0;
      row_ptr           <= '0;
      shift_k           <= '0;
      collide           <= 1'b0;
      movement_commit   <= 1'b0;
      movement_declined <= 1'b0;
      movement_steal    <= 1'b0;
      lines_cleared     <= '0;
      game_over         <= 1'b0;
    end else begin
      state             <= state_next;
      blk               <= blk_next;
      row_ptr           <= row_next;
      shift_k           <= shift_next;
      collide           <= collide_next;
      movement_commit   <= commit_next;
      movement_declined <= declined_next;
      movement_steal    <= steal_next;
      if (lc_inc && (lines_cleared != '1)) lines_cleared <= lines_cleared + CNT_W'(1);
      if (go_set) game_over <= 1'b1;
    end
  end

  // Request capture: candidate blocks, intent and colour
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned k = 0; k < NBLK; k++) begin
        lat_h[k] <= '0;
        lat_v[k] <= '0;
      end
      lat_intent <= 1'b0;
      lat_color  <= '0;
    end else if (latch_en) begin
      lat_h[0]   <= P1blk_h;
      lat_v[0]   <= P1blk_v;
      lat_h[1]   <= P2blk_h;
      lat_v[1]   <= P2blk_v;
      lat_h[2]   <= P3blk_h;
      lat_v[2]   <= P3blk_v;
      lat_h[3]   <= P4blk_h;
      lat_v[3]   <= P4blk_v;
      lat_intent <= movement_intent;
      lat_color  <= volatile_blk_color;
    end
  end

  // Playfield storage: lock writes, row shift-down and top-row clear
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned r = 0; r < FIELD_H; r++) field[r] <= '0;
    end else begin
      if (wr_en)    field[ROW_W'(lock_h)][COL_W'(cur_v)] <= lat_color;
      if (shift_en) field[shift_k] <= field[shift_k - ROW_W'(1)];
      if (clr_row0) field[0] <= '0;
    end
  end

  // Registered renderer read port; out-of-range coordinates read as empty
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_color <= '0;
    end else if ((rd_h < H_LIM) && (rd_v < W_LIM)) begin
      rd_color <= field[ROW_W'(rd_h)][COL_W'(rd_v)];
    end else begin
      rd_color <= '0;
    end
  end

endmodule
